scan_ctrl: RTL and testbench

//   Time-multiplexes N_DIG 7-segment digits onto one shared segment bus.

---
 rtl/scan_if.sv | 31 +++
 rtl/scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_scan_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/scan_if.sv
// Display bus between the digit source and the scan controller.
//   dig_data   : 4-bit code per digit, digit i = dig_data[4i+3:4i]
//   dp_in      : decimal point per digit, 1 = lit
//   flash_mask : 1 = digit blinks with the blink phase
//   blank_mask : 1 = digit always dark
//   an         : anode enables, one-hot or zero, active high
//   seg        : segments a..g on seg[0..6], active high
//   dp         : decimal point, active high
//   cur_dig    : index of the digit currently selected
interface scan_if #(
  parameter int unsigned N_DIG = 8
);
  logic [4*N_DIG-1:0] dig_data;
  logic [N_DIG-1:0]   dp_in;
  logic [N_DIG-1:0]   flash_mask;
  logic [N_DIG-1:0]   blank_mask;
  logic [N_DIG-1:0]   an;
  logic [6:0]         seg;
  logic               dp;
  logic [2:0]         cur_dig;

  modport master (
    output dig_data, dp_in, flash_mask, blank_mask,
    input  an, seg, dp, cur_dig
  );

  modport slave (
    input  dig_data, dp_in, flash_mask, blank_mask,
    output an, seg, dp, cur_dig
  );
endinterface

// File: rtl/scan_ctrl.sv
// Multiplexed 7-segment scan controller with anti-ghost blanking,
// per-digit flash and blank masks.
//   clk, rst  : system clock, synchronous active-high reset
//   en        : 1 = scan, 0 = display dark and index frozen
//   clk_scan  : scan-rate square wave, each rising edge advances one digit
//   clk_2Hz   : blink phase square wave
//   bus       : digit data in, anode/segment/dp/index out (all registered)
module scan_ctrl #(
  parameter int unsigned N_DIG     = 8,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clk_scan,
  input  logic clk_2Hz,
  scan_if.slave bus
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned SEG_W  = 7;

  logic               scan_s1_q, scan_s1_d;
  logic               scan_s2_q, scan_s2_d;
  logic               scan_s3_q, scan_s3_d;
  logic               blink_s1_q, blink_s1_d;
  logic               blink_s2_q, blink_s2_d;
  logic [IDX_W-1:0]   cur_dig_q, cur_dig_d;
  logic [CNT_W-1:0]   blank_cnt_q, blank_cnt_d;
  logic               run_q, run_d;
  logic [CODE_W-1:0]  snap_code_q, snap_code_d;
  logic               snap_dp_q, snap_dp_d;
  logic               snap_flash_q, snap_flash_d;
  logic               snap_blank_q, snap_blank_d;
  logic [N_DIG-1:0]   an_q, an_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               dp_q, dp_d;

  logic               tick;
  logic               phase;
  logic               lit;
  logic               dark;
  logic [IDX_W-1:0]   next_dig;

  function automatic logic [SEG_W-1:0] seg_decode(input logic [CODE_W-1:0] code);
    logic [SEG_W-1:0] s;
    s = '0;
    case (code)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      4'd10:   s = 7'h40;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Next-state and registered-output computation
  always_comb begin
    scan_s1_d    = clk_scan;
    scan_s2_d    = scan_s1_q;
    scan_s3_d    = scan_s2_q;
    blink_s1_d   = clk_2Hz;
    blink_s2_d   = blink_s1_q;
    cur_dig_d    = cur_dig_q;
    blank_cnt_d  = blank_cnt_q;
    run_d        = run_q;
    snap_code_d  = snap_code_q;
    snap_dp_d    = snap_dp_q;
    snap_flash_d = snap_flash_q;
    snap_blank_d = snap_blank_q;

    tick     = scan_s2_q & ~scan_s3_q;
    phase    = blink_s2_q;
    next_dig = (cur_dig_q == IDX_W'(N_DIG - 1)) ? '0 : cur_dig_q + IDX_W'(1);

    if (en && tick) begin
      // Advance and snapshot the new digit so mid-digit data changes cannot tear
      cur_dig_d    = next_dig;
      snap_code_d  = bus.dig_data[{next_dig, 2'b00} +: CODE_W];
      snap_dp_d    = bus.dp_in[next_dig];
      snap_flash_d = bus.flash_mask[next_dig];
      snap_blank_d = bus.blank_mask[next_dig];
      blank_cnt_d  = CNT_W'(BLANK_CYC);
      run_d        = 1'b1;
    end else if (blank_cnt_q != '0) begin
      blank_cnt_d = blank_cnt_q - CNT_W'(1);
    end

    // Leaving enable drops the display until the next accepted tick
    if (!en) begin
      run_d = 1'b0;
    end

    lit  = run_d && (blank_cnt_d == '0);
    dark = snap_blank_d | (snap_flash_d & ~phase);

    an_d  = lit ? (N_DIG'(1) << cur_dig_d) : '0;
    seg_d = (lit && !dark) ? seg_decode(snap_code_d) : '0;
    dp_d  = lit & ~dark & snap_dp_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_s1_q    <= 1'b0;
      scan_s2_q    <= 1'b0;
      scan_s3_q    <= 1'b0;
      blink_s1_q   <= 1'b0;
      blink_s2_q   <= 1'b0;
      cur_dig_q    <= '0;
      blank_cnt_q  <= '0;
      run_q        <= 1'b0;
      snap_code_q  <= '0;
      snap_dp_q    <= 1'b0;
      snap_flash_q <= 1'b0;
      snap_blank_q <= 1'b0;
      an_q         <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
    end else begin
      scan_s1_q    <= scan_s1_d;
      scan_s2_q    <= scan_s2_d;
      scan_s3_q    <= scan_s3_d;
      blink_s1_q   <= blink_s1_d;
      blink_s2_q   <= blink_s2_d;
      cur_dig_q    <= cur_dig_d;
      blank_cnt_q  <= blank_cnt_d;
      run_q        <= run_d;
      snap_code_q  <= snap_code_d;
      snap_dp_q    <= snap_dp_d;
      snap_flash_q <= snap_flash_d;
      snap_blank_q <= snap_blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.an      = an_q;
  assign bus.seg     = seg_q;
  assign bus.dp      = dp_q;
  assign bus.cur_dig = cur_dig_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Scoreboard bench for scan_ctrl: a timestamp-based reference model predicts
// the display outputs for every clock edge, a monitor compares them.
module tb_scan_ctrl;

  localparam int unsigned N_DIG     = 8;
  localparam int unsigned BLANK_CYC = 16;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic clk_scan;
  logic clk_2Hz;

  scan_if #(.N_DIG(N_DIG)) bus ();

  scan_ctrl #(.N_DIG(N_DIG), .BLANK_CYC(BLANK_CYC)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clk_scan (clk_scan),
    .clk_2Hz  (clk_2Hz),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned edge_no;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  cur;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int passed = 0;

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  // Reference model state: which digit is shown, from which edge it is visible,
  // and the digit attributes captured when it was selected.
  int unsigned edge_n     = 0;
  int unsigned m_idx      = 0;
  int unsigned m_lit_edge = 0;
  bit          m_run      = 0;
  logic [3:0]  m_code     = '0;
  bit          m_dp = 0, m_fl = 0, m_bl = 0;
  bit          sc1 = 0, sc2 = 0, sc3 = 0, bk1 = 0, bk2 = 0;

  // Stimulus generator state
  int unsigned scan_half = 32, scan_cnt = 0;
  int unsigned blink_half = 1000, blink_cnt = 0;
  bit          rand_mode = 0;

  task automatic model_step(input int unsigned e);
    exp_t x;
    bit   tick, phase, visible, dark;
    x.edge_no = e;
    if (rst) begin
      m_idx = 0; m_run = 0; m_lit_edge = 0;
      sc1 = 0; sc2 = 0; sc3 = 0; bk1 = 0; bk2 = 0;
      x.an = '0; x.seg = '0; x.dp = 1'b0; x.cur = '0;
    end else begin
      tick  = sc2 && !sc3;
      phase = bk2;
      if (!en) begin
        m_run = 0;
      end else if (tick) begin
        m_idx      = (m_idx + 1) % N_DIG;
        m_code     = bus.dig_data[4*m_idx +: 4];
        m_dp       = bus.dp_in[m_idx];
        m_fl       = bus.flash_mask[m_idx];
        m_bl       = bus.blank_mask[m_idx];
        m_run      = 1;
        m_lit_edge = e + BLANK_CYC;
      end
      visible = m_run && (e >= m_lit_edge);
      dark    = m_bl || (m_fl && !phase);
      x.an    = visible ? (8'd1 << m_idx) : 8'd0;
      x.seg   = (visible && !dark) ? seg_tbl[m_code] : 7'd0;
      x.dp    = visible && !dark && m_dp;
      x.cur   = 3'(m_idx);
      sc3 = sc2; sc2 = sc1; sc1 = clk_scan;
      bk2 = bk1; bk1 = clk_2Hz;
    end
    exp_q.push_back(x);
  endtask

  // One clock: predict the edge from the inputs it samples, then drive the next cycle
  task automatic cycle();
    @(posedge clk);
    edge_n++;
    model_step(edge_n);
    #1;
    scan_cnt++;
    if (scan_cnt >= scan_half) begin
      scan_cnt = 0;
      clk_scan = ~clk_scan;
      if (rand_mode) scan_half = $urandom_range(40, 5);
    end
    blink_cnt++;
    if (blink_cnt >= blink_half) begin
      blink_cnt = 0;
      clk_2Hz = ~clk_2Hz;
      if (rand_mode) blink_half = $urandom_range(30, 5);
    end
  endtask

  // Monitor: every edge presents a display word; compare against the oldest prediction
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      checks++;
      if (bus.an === x.an && bus.seg === x.seg && bus.dp === x.dp && bus.cur_dig === x.cur)
        passed++;
      else
        $display("FAIL disp@edge%0d: got an=%h seg=%h dp=%b cur=%0d, want an=%h seg=%h dp=%b cur=%0d",
                 x.edge_no, bus.an, bus.seg, bus.dp, bus.cur_dig, x.an, x.seg, x.dp, x.cur);
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; clk_scan = 1'b0; clk_2Hz = 1'b0;
    bus.dig_data   = 32'h7654_3210;
    bus.dp_in      = 8'h00;
    bus.flash_mask = 8'h00;
    bus.blank_mask = 8'h00;

    // Reset, then a dark display until the first scan edge
    repeat (3) cycle();
    rst = 1'b0;

    // Nine scan rises over ascending codes, including the 7->0 wrap
    repeat (9 * 64 + 40) cycle();

    // Flashing digit 0 showing 8 while the blink phase toggles
    bus.flash_mask     = 8'h01;
    bus.dig_data[3:0]  = 4'h8;
    bus.dp_in          = 8'h05;
    blink_half         = 7;
    repeat (800) cycle();

    // Leading blank, off code and dash
    bus.flash_mask = 8'h00;
    bus.blank_mask = 8'h80;
    bus.dig_data   = 32'h7FA4_3218;
    repeat (600) cycle();

    // Disable mid-frame at digit 3 across several scan edges
    bus.blank_mask = 8'h00;
    for (int i = 0; i < 2000 && m_idx != 3; i++) cycle();
    repeat (20) cycle();
    en = 1'b0;
    repeat (5 * 64) cycle();
    en = 1'b1;
    repeat (200) cycle();

    // Random traffic: data changes mid-digit, irregular scan edges, enable and reset pulses
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49, 0) == 0) bus.dig_data   = $urandom;
      if ($urandom_range(49, 0) == 0) bus.dp_in      = 8'($urandom);
      if ($urandom_range(79, 0) == 0) bus.flash_mask = 8'($urandom);
      if ($urandom_range(79, 0) == 0) bus.blank_mask = 8'($urandom);
      if ($urandom_range(299, 0) == 0) en = ~en;
      rst = ($urandom_range(699, 0) == 0);
      cycle();
    end
    rst = 1'b0;
    en  = 1'b1;
    repeat (100) cycle();

    // Let the monitor consume the final prediction, then confirm nothing is left over
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
